// File: rtl/frame_builder.sv
`default_nettype none
// frame_builder -- pops FIFO samples into a FRAME_LEN ring and streams overlapping
// frames (FRAME_LEN long, advancing HOP samples) to the windowing stage. Rev 1.0
module frame_builder #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             frame_first_o,
    output logic             frame_last_o,
    output logic             busy_o
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FILL_TARGET = CW'(FRAME_LEN);
    localparam logic [CW-1:0] HOP_TARGET  = CW'(HOP);
    localparam logic [CW-1:0] LAST_IDX    = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_idx;
    logic [CW-1:0]    req_cnt;
    logic [CW-1:0]    cap_cnt;
    logic [CW-1:0]    idx;
    logic             pend;
    logic [CW-1:0]    target;
    logic             fill_done;
    logic             handshake;
    logic [WIDTH-1:0] ring [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        target       = (state == FILL) ? FILL_TARGET : HOP_TARGET;
        fifo_rd_en_o = 1'b0;
        fill_done    = 1'b0;
        handshake    = sample_valid_o && sample_ready_i;
        case (state)
            FILL, REFILL: begin
                fifo_rd_en_o = !fifo_empty_i && (req_cnt < target);
                // The capture completing the target is the one landing this cycle.
                fill_done    = pend && (cap_cnt == target - CW'(1));
                if (fill_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (handshake && frame_last_o) begin
                    state_next = REFILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    assign busy_o = (state != FILL) || (req_cnt != '0);

    always_ff @(posedge clk) begin
        if (pend) begin
            ring[wr_ptr] <= fifo_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_idx         <= '0;
            req_cnt        <= '0;
            cap_cnt        <= '0;
            idx            <= '0;
            pend           <= 1'b0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            frame_first_o  <= 1'b0;
            frame_last_o   <= 1'b0;
        end else begin
            pend <= fifo_rd_en_o;
            if (fifo_rd_en_o) begin
                req_cnt <= req_cnt + CW'(1);
            end
            if (pend) begin
                wr_ptr  <= wr_ptr + AW'(1);
                cap_cnt <= cap_cnt + CW'(1);
            end
            if (fill_done) begin
                req_cnt <= '0;
                cap_cnt <= '0;
                // Slot just past the final write holds the oldest sample of the window.
                rd_idx  <= wr_ptr + AW'(1);
            end
            if (state == EMIT) begin
                if (!sample_valid_o || (handshake && !frame_last_o)) begin
                    sample_o       <= ring[rd_idx];
                    frame_first_o  <= (idx == '0);
                    frame_last_o   <= (idx == LAST_IDX);
                    sample_valid_o <= 1'b1;
                    rd_idx         <= rd_idx + AW'(1);
                    idx            <= idx + CW'(1);
                end else if (handshake) begin
                    sample_valid_o <= 1'b0;
                    frame_first_o  <= 1'b0;
                    frame_last_o   <= 1'b0;
                    idx            <= '0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_builder.sv
`default_nettype none
// tb_frame_builder -- three frame_builder instances (HOP=4, 8, 1; FRAME_LEN=8) fed by
// FIFO models; outputs checked against frame k sample j = input[k*HOP+j].
module tb_frame_builder;
    localparam int W  = 16;
    localparam int FL = 8;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]        fifo_empty, rd_en, valid, ready, first, last, busy, gate;
    logic [N-1:0][W-1:0] fdata, sample;
    logic [W-1:0]        mem [N][256];
    int wp [N];
    int rp [N];
    int base [N];
    int out_n [N];
    int rds [N];
    logic [N-1:0]        prev_stall, prev_run, prev_first, prev_last;
    logic [N-1:0][W-1:0] prev_sample;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic int hop_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int H = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
        assign fifo_empty[g] = (wp[g] == rp[g]) || gate[g];
        frame_builder #(.WIDTH(W), .FRAME_LEN(FL), .HOP(H)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .fifo_empty_i   (fifo_empty[g]),
            .fifo_rd_en_o   (rd_en[g]),
            .fifo_data_i    (fdata[g]),
            .sample_o       (sample[g]),
            .sample_valid_o (valid[g]),
            .sample_ready_i (ready[g]),
            .frame_first_o  (first[g]),
            .frame_last_o   (last[g]),
            .busy_o         (busy[g])
        );
    end

    // FIFO models: registered read data, one cycle after the strobe
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en[i] && (rp[i] != wp[i])) begin
                fdata[i] <= mem[i][rp[i]];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int v);
        mem[i][wp[i]] = W'(v);
        wp[i] = wp[i] + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every handshake against the frame-indexing model
    always @(negedge clk) begin
        int k, j, src;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                base[i]       = wp[i];
                out_n[i]      = 0;
                rds[i]        = 0;
                prev_stall[i] = 1'b0;
                prev_run[i]   = 1'b0;
            end else begin
                if (rd_en[i]) begin
                    check("rd_while_empty", int'(fifo_empty[i]), 0);
                    rds[i]++;
                end
                if (prev_stall[i]) begin
                    check("hold_valid", int'(valid[i]), 1);
                    check("hold_sample", int'(sample[i]), int'(prev_sample[i]));
                    check("hold_flags", int'({first[i], last[i]}), int'({prev_first[i], prev_last[i]}));
                end
                if (prev_run[i]) begin
                    check("no_bubble", int'(valid[i]), 1);
                end
                if (valid[i] && ready[i]) begin
                    k   = out_n[i] / FL;
                    j   = out_n[i] % FL;
                    src = base[i] + k * hop_of(i) + j;
                    check("src_in_range", int'(src < wp[i]), 1);
                    if (src < wp[i]) begin
                        check("sample", int'(sample[i]), int'(mem[i][src]));
                    end
                    check("first", int'(first[i]), int'(j == 0));
                    check("last", int'(last[i]), int'(j == FL - 1));
                    if (j == 0) begin
                        check("reads_per_frame", rds[i], (k == 0) ? FL : hop_of(i));
                        rds[i] = 0;
                    end
                    out_n[i]++;
                end
                prev_stall[i]  = valid[i] && !ready[i];
                prev_run[i]    = valid[i] && ready[i] && !last[i];
                prev_sample[i] = sample[i];
                prev_first[i]  = first[i];
                prev_last[i]   = last[i];
            end
        end
    end

    task automatic expect_frame_start(input int i, input int exp_v, input string name);
        bit found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (valid[i] && ready[i] && first[i]) found = 1'b1;
        end
        if (found) check(name, int'(sample[i]), exp_v);
        else check({name, "_timeout"}, 0, 1);
    endtask

    task automatic expect_count(input int i, input int n, input string name);
        for (int c = 0; c < 1000 && out_n[i] < n; c++) @(negedge clk);
        repeat (12) @(negedge clk);
        check(name, out_n[i], n);
    endtask

    task automatic check_idle_zero(input int i, input string tag);
        check({tag, "_sample"}, int'(sample[i]), 0);
        check({tag, "_valid"}, int'(valid[i]), 0);
        check({tag, "_first"}, int'(first[i]), 0);
        check({tag, "_last"}, int'(last[i]), 0);
        check({tag, "_busy"}, int'(busy[i]), 0);
        check({tag, "_rd_en"}, int'(rd_en[i]), 0);
    endtask

    initial begin
        int  run;
        bit  found;
        rst_n = 1'b0;
        gate  = '0;
        ready = '1;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) check_idle_zero(i, "reset");

        // 1: frame 0..7 with ready held high
        tick();
        for (int v = 0; v < 8; v++) push(0, v);
        run = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_en[0]) run++;
            else if (run != 0) break;
        end
        check("t1_rd_run", run, 8);
        expect_frame_start(0, 0, "t1_first_sample");
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            check("t1_seq_valid", int'(valid[0]), 1);
            check("t1_seq_sample", int'(sample[0]), j);
        end
        check("t1_last_flag", int'(last[0]), 1);
        @(negedge clk);
        check("t1_valid_drop", int'(valid[0]), 0);
        check("t1_busy_refill", int'(busy[0]), 1);

        // 2: continue the ramp -> frames 4..11 and 8..15
        tick();
        for (int v = 8; v < 16; v++) push(0, v);
        expect_frame_start(0, 4, "t2_frame1_first");
        expect_frame_start(0, 8, "t2_frame2_first");
        expect_count(0, 24, "t2_count");

        // 3: empty flag toggling during fill
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gate[0] = 1'b1;
        for (int v = 0; v < 8; v++) push(0, v);
        for (int c = 0; c < 12; c++) begin
            tick();
            gate[0] = ~gate[0];
        end
        gate[0] = 1'b0;
        expect_frame_start(0, 0, "t3_first_sample");
        expect_count(0, 8, "t3_count");

        // 4: backpressure at sample 5
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int v = 0; v < 8; v++) push(0, v);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (valid[0] && ready[0] && sample[0] == W'(4)) found = 1'b1;
        end
        check("t4_reach_4", int'(found), 1);
        tick();
        ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_hold_sample", int'(sample[0]), 5);
            check("t4_hold_valid", int'(valid[0]), 1);
        end
        tick();
        ready[0] = 1'b1;
        @(negedge clk);
        check("t4_release_5", int'(sample[0]), 5);
        @(negedge clk);
        check("t4_then_6", int'(sample[0]), 6);
        @(negedge clk);
        check("t4_then_7", int'(sample[0]), 7);
        check("t4_last_7", int'(last[0]), 1);
        expect_count(0, 8, "t4_count");

        // 5: reset in the middle of a fill
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int v = 0; v < 3; v++) push(0, v);
        repeat (6) tick();
        check("t5_busy_partial", int'(busy[0]), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero(0, "t5_post_reset");
        tick();
        for (int v = 100; v < 108; v++) push(0, v);
        expect_frame_start(0, 100, "t5_first_sample");
        expect_count(0, 8, "t5_count");

        // 6: HOP=8 and HOP=1 on a slowly fed ramp 0..23
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fork
            begin
                for (int v = 0; v < 24; v++) begin
                    push(1, v);
                    push(2, v);
                    tick();
                    tick();
                end
            end
            begin
                expect_frame_start(1, 0, "t6_h8_frame0");
                expect_frame_start(1, 8, "t6_h8_frame1");
            end
            begin
                expect_frame_start(2, 0, "t6_h1_frame0");
                expect_frame_start(2, 1, "t6_h1_frame1");
                expect_frame_start(2, 2, "t6_h1_frame2");
            end
        join
        expect_count(1, 24, "t6_h8_count");
        expect_count(2, 136, "t6_h1_count");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d vectors, expected completion", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
